fft16_output_serializer: RTL
============================

Name: fft16_output_serializer

Overview:
- Reader-side counterpart of the FFT input buffer. Snapshots the 16 parallel complex FFT bins on a start pulse.
- Streams the snapshot out one bin per transfer over a valid/ready interface, with bin address and last flag.
- Sits after the stage-2 butterfly network. Feeds a narrow downstream consumer such as a UART/DMA packer or a bench monitor.

Parameters:
- WIDTH, 16, bit width of each real and imaginary sample (signed two's complement).
- N, 16, number of bins. Fixed at 16; other values are unsupported. Address width is 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; capture the inputs and begin streaming
- yr_in_flat  input  N*WIDTH  real bins; bin k at [k*WIDTH +: WIDTH]
- yi_in_flat  input  N*WIDTH  imaginary bins; same packing
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- out_valid  output  1  out_yr/out_yi/out_addr/out_last hold a valid bin
- out_ready  input  1  consumer accepts the current bin
- out_addr  output  4  bin index of the current output
- out_yr  output  WIDTH  real part of the current bin
- out_yi  output  WIDTH  imaginary part of the current bin
- out_last  output  1  high with the bin whose out_addr is 15
- done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Stated interface fact: one clock; reset is synchronous and active-high (clk, rst).
- All outputs are registered.
- Reset (any state, including mid-stream):
  - state=IDLE, counter=0, snapshot registers cleared to 0.
  - busy=0, out_valid=0, out_addr=0, out_yr=0, out_yi=0, out_last=0, done=0.
  - A transfer in progress is abandoned with no done pulse.
- State IDLE:
  - start=1: latch all 32 input words into the snapshot, counter=0, go to STREAM.
  - start=0: remain in IDLE; outputs hold their last values with out_valid=0.
- State STREAM:
  - First cycle in STREAM: out_valid=1, out_addr=0, data = snapshot bin 0, out_last=0. Latency is start to first out_valid = 1 cycle.
  - Transfer occurs when out_valid && out_ready.
  - On transfer with counter<15: counter+1; next cycle presents the next bin.
  - Back-to-back transfers are sustained at 1 bin/cycle while out_ready stays high.
  - With out_valid=1 and out_ready=0: all output fields stay stable; no bin is skipped or repeated.
  - out_last=1 exactly when out_addr=15.
  - Transfer with counter=15: out_valid=0 next cycle, go to DONE.
- State DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- busy=1 in STREAM and DONE.
- start while busy=1: ignored; snapshot unchanged, no restart.
- start in the same cycle as the IDLE return: treated as busy and ignored. A new start is accepted only while in IDLE.
- out_ready is ignored while out_valid=0.
- Snapshot isolation: changes on yr_in_flat/yi_in_flat after the capture cycle have no effect on the streamed data.
- No arithmetic is performed; samples pass through bit-exact.

Optional Feature:
- Macro: FFT16_SER_BITREV_EN.
- Defined:
  - Output position p (counter value) presents snapshot index bitrev4(p), so natural-order bins are produced from a bit-reversed network output.
  - out_addr still reports p (0..15 ascending); out_last still at p=15.
  - Example: p=1 reads bin 8, p=3 reads bin 12.
- Undefined: position p presents snapshot bin p directly.
- Handshake, latency and state machine are identical in both builds.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then low; no start.
  - Required: all outputs 0 for 10 cycles; busy=0, out_valid=0.
- Full stream, no backpressure:
  - Stimulus: load bin k with yr=k*100, yi=-k; pulse start; out_ready=1.
  - Required: out_valid from cycle +1 for 16 consecutive cycles; out_addr 0..15; out_yr 0,100..1500; out_yi 0,-1..-15.
  - Required: out_last only at addr 15; done pulses on the following cycle.
- Backpressure:
  - Stimulus: as above, with out_ready low on every odd cycle.
  - Required: each bin is held stable while stalled; exactly 16 transfers in order; done appears once, after the transfer of addr 15.
- Snapshot and start-while-busy:
  - Stimulus: after start, change all inputs to 0x7FFF and pulse start again at addr 5.
  - Required: the original values stream unchanged; no restart; exactly 16 transfers.
- Reset mid-stream:
  - Stimulus: assert rst after the transfer of addr 7.
  - Required: next cycle all outputs 0, state IDLE, no done pulse.
  - Required: a new start then streams again from addr 0.
- Bit-reverse build (FFT16_SER_BITREV_EN defined):
  - Stimulus: bin k yr=k; start; out_ready=1.
  - Required: out_yr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_addr 0..15.

Source files
------------

// File: rtl/fft16_ser_if.sv
// Stream interface carrying one complex FFT bin per transfer.
// Signals:
//   out_valid - producer holds a valid bin
//   out_ready - consumer accepts the current bin
//   out_addr  - 4-bit bin position
//   out_yr    - real part (WIDTH, signed)
//   out_yi    - imaginary part (WIDTH, signed)
//   out_last  - high with position 15
// master: producer side. slave: consumer side.
interface fft16_ser_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned AW = 4;

    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_addr;
    logic [WIDTH-1:0] out_yr;
    logic [WIDTH-1:0] out_yi;
    logic             out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_yr,
        output out_yi,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_yr,
        input  out_yi,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft16_output_serializer.sv
// Snapshots 16 parallel complex FFT bins on a start pulse and streams
// them out one bin per valid/ready transfer, with bin address and last.
// Optional build macro FFT16_SER_BITREV_EN: position p reads snapshot
// bin bitrev4(p), turning bit-reversed network output into natural order.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous reset, active-high
//   start      - one-cycle pulse; capture inputs and begin streaming
//   yr_in_flat - real bins, bin k at [k*WIDTH +: WIDTH]
//   yi_in_flat - imaginary bins, same packing
//   busy       - high in STREAM and DONE
//   done       - one-cycle pulse after the final transfer
//   ser        - output stream (fft16_ser_if master)
module fft16_output_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   yr_in_flat,
    input  logic [N*WIDTH-1:0]   yi_in_flat,
    output logic                 busy,
    output logic                 done,
    fft16_ser_if.master          ser
);
    localparam int unsigned AW = 4;
    localparam logic [AW-1:0] LAST_POS = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] snap_r [N];
    logic [WIDTH-1:0] snap_i [N];

    logic             capture;
    logic             busy_d;
    logic             done_d;
    logic             valid_d;
    logic [AW-1:0]    addr_d;
    logic [WIDTH-1:0] yr_d;
    logic [WIDTH-1:0] yi_d;
    logic             last_d;
    logic [AW-1:0]    nxt_pos;
    logic [AW-1:0]    nxt_src;

    // Snapshot index presented at output position p.
    function automatic logic [AW-1:0] src_idx(input logic [AW-1:0] p);
`ifdef FFT16_SER_BITREV_EN
        return {p[0], p[1], p[2], p[3]};
`else
        return p;
`endif
    endfunction

    assign nxt_pos = cnt_q + AW'(1);
    assign nxt_src = src_idx(nxt_pos);

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ser.out_valid <= 1'b0;
            ser.out_addr  <= '0;
            ser.out_yr    <= '0;
            ser.out_yi    <= '0;
            ser.out_last  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy          <= busy_d;
            done          <= done_d;
            ser.out_valid <= valid_d;
            ser.out_addr  <= addr_d;
            ser.out_yr    <= yr_d;
            ser.out_yi    <= yi_d;
            ser.out_last  <= last_d;
        end
    end

    // Snapshot capture; only written on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) begin
                snap_r[k] <= '0;
                snap_i[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < int'(N); k++) begin
                snap_r[k] <= yr_in_flat[k*WIDTH +: WIDTH];
                snap_i[k] <= yi_in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        valid_d = ser.out_valid;
        addr_d  = ser.out_addr;
        yr_d    = ser.out_yr;
        yi_d    = ser.out_yi;
        last_d  = ser.out_last;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    // First bin comes straight from the inputs being
                    // captured; position 0 maps to bin 0 in both builds.
                    capture = 1'b1;
                    state_d = S_STREAM;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    addr_d  = '0;
                    yr_d    = yr_in_flat[WIDTH-1:0];
                    yi_d    = yi_in_flat[WIDTH-1:0];
                    last_d  = 1'b0;
                end
            end

            S_STREAM: begin
                if (ser.out_valid && ser.out_ready) begin
                    if (cnt_q == LAST_POS) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d  = nxt_pos;
                        addr_d = nxt_pos;
                        yr_d   = snap_r[nxt_src];
                        yi_d   = snap_i[nxt_src];
                        last_d = (nxt_pos == LAST_POS);
                    end
                end
            end

            S_DONE: begin
                // start seen here is ignored; only IDLE accepts it.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end
endmodule
